alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// ALU sequencing controller: queues up to two commands, issues them one at a
// time to an external multi-cycle ALU, waits for completion with a timeout,
// and holds each result until the consumer takes it.

package alu_seq_ctrl_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned DATA_W = 8;

    // One queued command as it sits in the FIFO.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              chain;
    } cmd_t;

endpackage

module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_chain,
    output logic              alu_start,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic              busy
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned PTR_W = 1;
    localparam int unsigned CNTF_W = 2;
    localparam logic [CNTF_W-1:0] FIFO_FULL = CNTF_W'(2);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    cmd_t                fifo_q [2];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNTF_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   last_q, last_d;
    logic                start_q, start_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rerr_q, rerr_d;
    logic                busy_q, busy_d;
    logic                push, pop;
    cmd_t                head;
    cmd_t                wr_entry;

    // Ready depends only on the registered fill level, so a same-cycle pop never raises it.
    assign cmd_ready = rst_n & ena & (count_q != FIFO_FULL);
    assign push      = cmd_valid & cmd_ready;
    assign pop       = (state_q == HOLD) & res_ready;
    assign head      = fifo_q[rd_ptr_q];
    assign wr_entry  = '{op: cmd_op, a: cmd_a, b: cmd_b, chain: cmd_chain};

    // Next fill level; the head stays queued until its result is consumed.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNTF_W'(1);
            2'b01:   count_d = count_q - CNTF_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        start_d  = 1'b0;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        unique case (state_q)
            IDLE: begin
                if (ena && (count_q != CNTF_W'(0))) begin
                    state_d = ISSUE;
                    start_d = 1'b1;
                    op_d    = head.op;
                    a_d     = head.chain ? last_q : head.a;
                    b_d     = head.b;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (alu_done) begin
                    // Completion on the timeout edge still counts as success.
                    rdata_d  = alu_result;
                    last_d   = alu_result;
                    rerr_d   = 1'b0;
                    rvalid_d = 1'b1;
                    state_d  = HOLD;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d  = '0;
                    rerr_d   = 1'b1;
                    rvalid_d = 1'b1;
                    state_d  = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (res_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) | (count_d != CNTF_W'(0));
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= '0;
            start_q  <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            start_q  <= start_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            busy_q   <= busy_d;
        end
    end

    // Command FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= wr_entry;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign alu_start = start_q;
    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign res_valid = rvalid_q;
    assign res_data  = rdata_q;
    assign res_err   = rerr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: command driver, behavioural ALU,
// result scoreboard, a vector table and hand-written corner sequences.

module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [7:0] cmd_a = '0;
    logic [7:0] cmd_b = '0;
    logic       cmd_chain = 1'b0;
    logic       alu_start;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_done = 1'b0;
    logic [7:0] alu_result = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_err;
    logic       busy;

    alu_seq_ctrl #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // dly: ALU answers dly cycles after alu_start; 0 means it never answers.
    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       chain;
        int         dly;
        logic [7:0] exp_a;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t drv_q[$];
    vec_t iss_q[$];
    vec_t res_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_res = 0;

    function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic chain, input int dly, input logic [7:0] exp_a,
                                input logic [7:0] exp_data, input logic exp_err);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.chain = chain; v.dly = dly;
        v.exp_a = exp_a; v.exp_data = exp_data; v.exp_err = exp_err;
        return v;
    endfunction

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return b;
            default: return a;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Command driver: holds cmd_valid until the handshake, then queues expectations.
    initial begin : driver
        vec_t cur;
        bit   acc;
        forever begin
            @(negedge clk);
            acc = 1'b0;
            if (rst_n && cmd_valid && cmd_ready) begin
                acc = 1'b1;
                iss_q.push_back(cur);
                res_q.push_back(cur);
            end
            @(posedge clk);
            #1;
            if (acc || !rst_n) cmd_valid = 1'b0;
            if (!cmd_valid && drv_q.size() > 0) begin
                cur       = drv_q.pop_front();
                cmd_op    = cur.op;
                cmd_a     = cur.a;
                cmd_b     = cur.b;
                cmd_chain = cur.chain;
                cmd_valid = 1'b1;
            end
        end
    end

    // Behavioural ALU: checks issued operands, answers after the per-command delay.
    initial begin : alu_model
        int         cnt;
        bit         act;
        logic [7:0] r;
        vec_t       e;
        cnt = 0; act = 1'b0; r = '0;
        forever begin
            @(negedge clk);
            alu_done = 1'b0;
            if (!rst_n) begin
                act = 1'b0;
                cnt = 0;
            end else begin
                if (act) begin
                    cnt--;
                    if (cnt == 0) begin
                        alu_done   = 1'b1;
                        alu_result = r;
                        act        = 1'b0;
                    end
                end
                if (alu_start) begin
                    if (iss_q.size() == 0) begin
                        check("issue_unexpected", 1, 0);
                    end else begin
                        e = iss_q.pop_front();
                        check("alu_op", 32'(alu_op), 32'(e.op));
                        check("alu_a", 32'(alu_a), 32'(e.exp_a));
                        check("alu_b", 32'(alu_b), 32'(e.b));
                        r   = alu_fn(alu_op, alu_a, alu_b);
                        cnt = e.dly;
                        act = (e.dly != 0);
                    end
                end
            end
        end
    end

    // Result monitor: every consumed result is compared in command order.
    initial begin : monitor
        vec_t e;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid && res_ready) begin
                n_res++;
                if (res_q.size() == 0) begin
                    check("result_unexpected", 1, 0);
                end else begin
                    e = res_q.pop_front();
                    check("res_data", 32'(res_data), 32'(e.exp_data));
                    check("res_err", 32'(res_err), 32'(e.exp_err));
                end
            end
        end
    end

    task automatic wait_drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (drv_q.size() == 0 && !cmd_valid && iss_q.size() == 0 &&
                res_q.size() == 0 && !busy) break;
        end
        check("drain_done", 32'(i < budget), 1);
    endtask

    task automatic wait_start(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (alu_start) break;
        end
        check("start_seen", 32'(alu_start), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_alu_start"}, 32'(alu_start), 0);
        check({tag, "_alu_op"}, 32'(alu_op), 0);
        check({tag, "_alu_a"}, 32'(alu_a), 0);
        check({tag, "_alu_b"}, 32'(alu_b), 0);
        check({tag, "_res_valid"}, 32'(res_valid), 0);
        check({tag, "_res_data"}, 32'(res_data), 0);
        check({tag, "_res_err"}, 32'(res_err), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[11];

    initial begin : main
        int n0, starts, rv;
        // op, a, b, chain, dly, exp_a, exp_data, exp_err  (last good result 0x46 on entry)
        tbl[0]  = mk(3'd0, 8'hFF, 8'h01, 1'b1, 2,  8'h46, 8'h47, 1'b0);
        tbl[1]  = mk(3'd1, 8'h10, 8'h03, 1'b0, 1,  8'h10, 8'h0D, 1'b0);
        tbl[2]  = mk(3'd2, 8'hF0, 8'h3C, 1'b0, 5,  8'hF0, 8'h30, 1'b0);
        tbl[3]  = mk(3'd3, 8'h0F, 8'h05, 1'b1, 1,  8'h30, 8'h35, 1'b0);
        tbl[4]  = mk(3'd4, 8'hAA, 8'h55, 1'b0, 0,  8'hAA, 8'h00, 1'b1);
        tbl[5]  = mk(3'd0, 8'h00, 8'h01, 1'b1, 4,  8'h35, 8'h36, 1'b0);
        tbl[6]  = mk(3'd1, 8'h00, 8'h01, 1'b0, 1,  8'h00, 8'hFF, 1'b0);
        tbl[7]  = mk(3'd0, 8'h00, 8'h02, 1'b1, 15, 8'hFF, 8'h01, 1'b0);
        tbl[8]  = mk(3'd0, 8'h00, 8'h02, 1'b1, 16, 8'h01, 8'h00, 1'b1);
        tbl[9]  = mk(3'd7, 8'h77, 8'h00, 1'b1, 1,  8'h01, 8'h01, 1'b0);
        tbl[10] = mk(3'd5, 8'h0F, 8'h00, 1'b0, 2,  8'h0F, 8'hF0, 1'b0);

        // Reset state with ena already high.
        ena = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        // Basic command accepted on the first edge after reset release.
        drv_q.push_back(mk(3'd0, 8'h12, 8'h34, 1'b0, 3, 8'h12, 8'h46, 1'b0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("first_cmd_ready", 32'(cmd_ready), 1);
        check("first_cmd_valid", 32'(cmd_valid), 1);
        @(negedge clk);
        check("basic_start_e1", 32'(alu_start), 0);
        check("basic_busy", 32'(busy), 1);
        @(negedge clk);
        check("basic_start_e2", 32'(alu_start), 1);
        @(negedge clk);
        check("basic_start_e3", 32'(alu_start), 0);
        check("basic_a_stable", 32'(alu_a), 32'h12);
        repeat (2) @(negedge clk);
        check("basic_valid_e5", 32'(res_valid), 0);
        @(negedge clk);
        check("basic_valid_e6", 32'(res_valid), 1);
        check("basic_data_e6", 32'(res_data), 32'h46);
        repeat (3) @(negedge clk);
        check("basic_valid_held", 32'(res_valid), 1);
        check("basic_data_held", 32'(res_data), 32'h46);
        @(posedge clk);
        #1 res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("basic_valid_cleared", 32'(res_valid), 0);

        // Vector table back to back with the consumer always ready.
        for (int i = 0; i < 11; i++) drv_q.push_back(tbl[i]);
        wait_drain(1500);
        check("table_result_count", 32'(n_res), 12);

        // Backpressure: two queued, third waits until the first result is taken.
        @(posedge clk);
        #1 res_ready = 1'b0;
        drv_q.push_back(mk(3'd0, 8'h01, 8'h01, 1'b0, 1, 8'h01, 8'h02, 1'b0));
        drv_q.push_back(mk(3'd0, 8'h02, 8'h02, 1'b0, 1, 8'h02, 8'h04, 1'b0));
        drv_q.push_back(mk(3'd0, 8'h03, 8'h03, 1'b0, 1, 8'h03, 8'h06, 1'b0));
        repeat (10) @(negedge clk);
        check("bp_cmd_ready_full", 32'(cmd_ready), 0);
        check("bp_third_pending", 32'(cmd_valid), 1);
        check("bp_res_valid", 32'(res_valid), 1);
        check("bp_res_data", 32'(res_data), 32'h02);
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_before_pop", 32'(cmd_ready), 0);
        @(negedge clk);
        check("bp_ready_after_pop", 32'(cmd_ready), 1);
        wait_drain(300);
        check("bp_result_count", 32'(n_res), 15);

        // ena low during WAIT: in-flight result delivered, queued command held.
        drv_q.push_back(mk(3'd0, 8'h10, 8'h01, 1'b0, 6, 8'h10, 8'h11, 1'b0));
        drv_q.push_back(mk(3'd0, 8'h20, 8'h01, 1'b0, 1, 8'h20, 8'h21, 1'b0));
        wait_start(50);
        @(posedge clk);
        #1 ena = 1'b0;
        n0 = n_res;
        for (int i = 0; i < 50 && n_res == n0; i++) @(negedge clk);
        check("ena_low_result", 32'(n_res), 32'(n0 + 1));
        starts = 0;
        repeat (10) begin
            @(negedge clk);
            if (alu_start) starts++;
        end
        check("ena_low_no_issue", 32'(starts), 0);
        check("ena_low_busy", 32'(busy), 1);
        check("ena_low_ready", 32'(cmd_ready), 0);
        @(posedge clk);
        #1 ena = 1'b1;
        wait_start(10);
        wait_drain(300);

        // Reset while waiting on a command that never completes, one more queued.
        drv_q.push_back(mk(3'd0, 8'h01, 8'h01, 1'b0, 0, 8'h01, 8'h00, 1'b1));
        drv_q.push_back(mk(3'd0, 8'h02, 8'h02, 1'b0, 1, 8'h02, 8'h04, 1'b0));
        wait_start(50);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        drv_q.delete();
        iss_q.delete();
        res_q.delete();
        @(negedge clk);
        check_reset_outputs("midwait");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        n0 = n_res;
        starts = 0;
        rv = 0;
        repeat (20) begin
            @(negedge clk);
            if (alu_start) starts++;
            if (res_valid) rv++;
        end
        check("post_reset_no_start", 32'(starts), 0);
        check("post_reset_no_valid", 32'(rv), 0);
        check("post_reset_busy", 32'(busy), 0);
        check("post_reset_no_result", 32'(n_res), 32'(n0));

        // Chain right after reset uses a cleared last result.
        drv_q.push_back(mk(3'd0, 8'h99, 8'h05, 1'b1, 1, 8'h00, 8'h05, 1'b0));
        wait_drain(100);
        check("final_result_count", 32'(n_res), 32'(n0 + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
